ssb_arbiter: RTL and testbench
==============================

// Module: ssb_arbiter
// PURPOSE
// Shares the single-port shared system bus (SRAM + debug memory + peripherals) between
// N bus hosts: debug SBA, Ibex instr, Ibex data. Hosts and device use req/gnt/rvalid
// protocol. One transaction in flight at a time; round-robin or fixed-priority selection;
// response timeout so a silent device cannot hang the core.
// Sits inside ibex_super_system between the hosts and the address decoder.
// PARAMETERS
// NumHosts       3   number of requesting hosts (index 0 = debug SBA, 1 = instr, 2 = data)
// AddrWidth      32  address width
// DataWidth      32  data width (byte enables = DataWidth/8)
// ArbMode        0   0 = round-robin, 1 = fixed priority (lowest index wins)
// TimeoutCycles  64  max cycles in RESP before error response; >=2
// PORTS
// clk_sys_i      in   1                  system clock
// rst_sys_i      in   1                  asynchronous active-high reset
// host_req_i     in   NumHosts           per-host request, held until host_gnt_o
// host_we_i      in   NumHosts           per-host write enable
// host_be_i      in   NumHosts*BE        per-host byte enables, host i at [i*BE +: BE]
// host_addr_i    in   NumHosts*AddrWidth per-host address, host i at [i*AW +: AW]
// host_wdata_i   in   NumHosts*DataWidth per-host write data
// host_gnt_o     out  NumHosts           one-hot grant pulse
// host_rvalid_o  out  NumHosts           one-hot response-valid pulse
// host_rdata_o   out  DataWidth          response data, shared, valid with host_rvalid_o
// host_err_o     out  1                  response error, valid with host_rvalid_o
// dev_req_o      out  1                  device request
// dev_we_o / dev_be_o / dev_addr_o / dev_wdata_o  out  1/BE/AW/DW  registered cmd of owner
// dev_gnt_i      in   1                  device accepted request
// dev_rvalid_i   in   1                  device response valid
// dev_rdata_i    in   DataWidth          device read data
// dev_err_i      in   1                  device error
// busy_o         out  1                  state != IDLE
// timeout_o      out  1                  sticky: a timeout occurred since reset
// BEHAVIOUR
// - Reset (async, immediate): state IDLE, all outputs 0, rr pointer = NumHosts-1
//   (host 0 wins first), owner = 0, timeout counter 0, timeout_o = 0.
// - FSM IDLE -> REQ -> RESP -> (IDLE | REQ).
// - IDLE: any host_req_i -> pick winner, register owner + its we/be/addr/wdata, go REQ.
//   RR: first requester at index ptr+1, ptr+2 ... wrapping mod NumHosts.
//   Fixed: lowest index.
// - REQ: dev_req_o = 1 with registered cmd. dev_gnt_i=1 -> host_gnt_o[owner]=1 same cycle
//   (combinational), dev_req_o drops next cycle, go RESP, counter cleared.
//   If owner deasserts host_req_i before dev_gnt_i: return to IDLE, no gnt, no rvalid.
// - RESP: counter increments each cycle. dev_rvalid_i=1 -> host_rvalid_o[owner]=1,
//   host_rdata_o = dev_rdata_i, host_err_o = dev_err_i (same cycle, combinational);
//   ptr <= owner.
//   Counter reaching TimeoutCycles without rvalid -> host_rvalid_o[owner]=1, err=1,
//   rdata=0, timeout_o <= 1; ptr <= owner.
// - Completion with any host_req_i high (incl. same host): arbitrate same cycle using
//   ptr = owner, register new cmd, go REQ directly. Else go IDLE.
//   Min 3 cycles/transaction, 2 back-to-back.
// - dev_rvalid_i outside RESP (late response after timeout) is dropped: no host_rvalid_o.
// - dev_gnt_i outside REQ is ignored. host_rdata_o = 0 and host_err_o = 0 whenever no
//   host_rvalid_o bit is set.
// - host_gnt_o, host_rvalid_o never have more than one bit set; never both for the same
//   transaction in the same cycle.
// - Counter width = $clog2(TimeoutCycles+1); it saturates and does not wrap.
// TESTING
// 1 Host 1 read at 0x100, dev_gnt 2 cyc later, rvalid next cyc rdata 0xDEADBEEF
//   -> host_gnt_o=3'b010 in gnt cycle, host_rvalid_o=3'b010, rdata 0xDEADBEEF, err 0.
// 2 All 3 hosts req continuously, device gnt immediately, rvalid next cycle
//   -> grant order 0,1,2,0,1,2 (ArbMode 0); 0,0,0,... (ArbMode 1); 2-cycle spacing.
// 3 Host 2 write addr 0x20, be 4'b0011, wdata 0x1234 -> dev_we_o=1, dev_be_o=4'b0011,
//   dev_addr_o=0x20, dev_wdata_o=0x1234 while dev_req_o.
// 4 TimeoutCycles=16, no rvalid -> 16 RESP cycles later host_rvalid_o[owner]=1,
//   err=1, rdata 0, timeout_o=1; later dev_rvalid_i produces no host_rvalid_o.
// 5 dev_err_i=1 with dev_rvalid_i for host 0 -> host_err_o=1 with host_rvalid_o=3'b001.
// 6 rst_sys_i asserted in RESP -> all outputs 0 immediately; after release with all
//   hosts requesting -> host 0 granted first.

Source files
------------

// File: rtl/ssb_arbiter.sv
// ssb_arbiter
// Shares the single-port system bus (SRAM, debug memory, peripherals) between
// NumHosts bus hosts (0 = debug SBA, 1 = Ibex instr, 2 = Ibex data). Hosts and
// the device both use req/gnt/rvalid. Only one transaction is in flight at a
// time. A response timeout stops a silent device from hanging the core.
//
// Ports
//   clk_sys_i, rst_sys_i            clock, async active-high reset
//   host_req/we/be/addr/wdata_i     per-host command, host i at slice i
//   host_gnt_o, host_rvalid_o       one-hot grant / response pulses
//   host_rdata_o, host_err_o        shared response, zero unless rvalid
//   dev_req_o, dev_we/be/addr/wdata_o  registered command of current owner
//   dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i  device handshake
//   busy_o                          FSM not idle
//   timeout_o                       sticky, a response timeout has occurred
module ssb_arbiter #(
    parameter int NumHosts      = 3,
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int ArbMode       = 0,
    parameter int TimeoutCycles = 64
) (
    input  logic                          clk_sys_i,
    input  logic                          rst_sys_i,
    input  logic [NumHosts-1:0]           host_req_i,
    input  logic [NumHosts-1:0]           host_we_i,
    input  logic [NumHosts*DataWidth/8-1:0] host_be_i,
    input  logic [NumHosts*AddrWidth-1:0] host_addr_i,
    input  logic [NumHosts*DataWidth-1:0] host_wdata_i,
    output logic [NumHosts-1:0]           host_gnt_o,
    output logic [NumHosts-1:0]           host_rvalid_o,
    output logic [DataWidth-1:0]          host_rdata_o,
    output logic                          host_err_o,
    output logic                          dev_req_o,
    output logic                          dev_we_o,
    output logic [DataWidth/8-1:0]        dev_be_o,
    output logic [AddrWidth-1:0]          dev_addr_o,
    output logic [DataWidth-1:0]          dev_wdata_o,
    input  logic                          dev_gnt_i,
    input  logic                          dev_rvalid_i,
    input  logic [DataWidth-1:0]          dev_rdata_i,
    input  logic                          dev_err_i,
    output logic                          busy_o,
    output logic                          timeout_o
);

    localparam int BeWidth = DataWidth / 8;
    localparam int OwnW    = (NumHosts > 1) ? $clog2(NumHosts) : 1;
    localparam int CntW    = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e          state_q, state_d;
    logic [OwnW-1:0] owner_q, ptr_q, arb_ptr, win;
    logic            win_vld, load;
    logic [CntW-1:0] cnt_q;
    logic            timed_out, done;

    // Per-host views of the flat command buses.
    logic [NumHosts-1:0][BeWidth-1:0]   host_be;
    logic [NumHosts-1:0][AddrWidth-1:0] host_addr;
    logic [NumHosts-1:0][DataWidth-1:0] host_wdata;

    assign host_be    = host_be_i;
    assign host_addr  = host_addr_i;
    assign host_wdata = host_wdata_i;

    // On completion the next pick starts after the finishing owner, so the
    // pointer used is owner_q before ptr_q has been updated.
    assign arb_ptr = (state_q == RESP) ? owner_q : ptr_q;

    // Loops run from the far end so the nearest candidate is written last.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        if (ArbMode == 1) begin
            for (int i = NumHosts - 1; i >= 0; i--) begin
                if (host_req_i[i]) begin
                    win     = OwnW'(i);
                    win_vld = 1'b1;
                end
            end
        end else begin
            for (int i = NumHosts; i >= 1; i--) begin
                if (host_req_i[OwnW'((int'(arb_ptr) + i) % NumHosts)]) begin
                    win     = OwnW'((int'(arb_ptr) + i) % NumHosts);
                    win_vld = 1'b1;
                end
            end
        end
    end

    // A response arriving on the timeout cycle itself is delivered normally.
    assign timed_out = (state_q == RESP) && !dev_rvalid_i &&
                       (cnt_q == CntW'(TimeoutCycles));
    assign done      = (state_q == RESP) && (dev_rvalid_i || timed_out);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    load    = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (dev_gnt_i)                state_d = RESP;
                else if (!host_req_i[owner_q]) state_d = IDLE;
            end
            RESP: begin
                if (done) begin
                    if (win_vld) begin
                        load    = 1'b1;
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_rdata_o  = '0;
        host_err_o    = 1'b0;
        if (state_q == REQ && dev_gnt_i) host_gnt_o[owner_q] = 1'b1;
        if (done) begin
            host_rvalid_o[owner_q] = 1'b1;
            if (timed_out) begin
                host_err_o = 1'b1;
            end else begin
                host_rdata_o = dev_rdata_i;
                host_err_o   = dev_err_i;
            end
        end
    end

    assign dev_req_o = (state_q == REQ);
    assign busy_o    = (state_q != IDLE);

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            ptr_q       <= OwnW'(NumHosts - 1);
            cnt_q       <= '0;
            timeout_o   <= 1'b0;
            dev_we_o    <= 1'b0;
            dev_be_o    <= '0;
            dev_addr_o  <= '0;
            dev_wdata_o <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                owner_q     <= win;
                dev_we_o    <= host_we_i[win];
                dev_be_o    <= host_be[win];
                dev_addr_o  <= host_addr[win];
                dev_wdata_o <= host_wdata[win];
            end
            if (done)      ptr_q     <= owner_q;
            if (timed_out) timeout_o <= 1'b1;
            // Saturating, so a stuck RESP cannot wrap back under the limit.
            if (state_q == REQ)
                cnt_q <= '0;
            else if (state_q == RESP && cnt_q != CntW'(TimeoutCycles))
                cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_ssb_arbiter.sv
// tb_ssb_arbiter
// Directed bench for ssb_arbiter. Two instances share all inputs: dut_a is
// round-robin, dut_b is fixed priority; both use a 16-cycle timeout.
module tb_ssb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  host_req, host_we;
    logic [11:0] host_be;
    logic [95:0] host_addr, host_wdata;
    logic        dev_gnt, dev_rvalid, dev_err;
    logic [31:0] dev_rdata;

    logic [2:0]  gnt_a, rvalid_a, gnt_b, rvalid_b;
    logic [31:0] rdata_a, rdata_b, daddr_a, daddr_b, dwdata_a, dwdata_b;
    logic [3:0]  dbe_a, dbe_b;
    logic        err_a, err_b, dreq_a, dreq_b, dwe_a, dwe_b;
    logic        busy_a, busy_b, tmo_a, tmo_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ssb_arbiter #(.NumHosts(3), .AddrWidth(32), .DataWidth(32), .ArbMode(0),
                  .TimeoutCycles(16)) dut_a (
        .clk_sys_i(clk), .rst_sys_i(rst),
        .host_req_i(host_req), .host_we_i(host_we), .host_be_i(host_be),
        .host_addr_i(host_addr), .host_wdata_i(host_wdata),
        .host_gnt_o(gnt_a), .host_rvalid_o(rvalid_a), .host_rdata_o(rdata_a),
        .host_err_o(err_a), .dev_req_o(dreq_a), .dev_we_o(dwe_a), .dev_be_o(dbe_a),
        .dev_addr_o(daddr_a), .dev_wdata_o(dwdata_a), .dev_gnt_i(dev_gnt),
        .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata), .dev_err_i(dev_err),
        .busy_o(busy_a), .timeout_o(tmo_a));

    ssb_arbiter #(.NumHosts(3), .AddrWidth(32), .DataWidth(32), .ArbMode(1),
                  .TimeoutCycles(16)) dut_b (
        .clk_sys_i(clk), .rst_sys_i(rst),
        .host_req_i(host_req), .host_we_i(host_we), .host_be_i(host_be),
        .host_addr_i(host_addr), .host_wdata_i(host_wdata),
        .host_gnt_o(gnt_b), .host_rvalid_o(rvalid_b), .host_rdata_o(rdata_b),
        .host_err_o(err_b), .dev_req_o(dreq_b), .dev_we_o(dwe_b), .dev_be_o(dbe_b),
        .dev_addr_o(daddr_b), .dev_wdata_o(dwdata_b), .dev_gnt_i(dev_gnt),
        .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata), .dev_err_i(dev_err),
        .busy_o(busy_b), .timeout_o(tmo_b));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] exp_a;
        logic       quiet;
        rst = 1'b1;
        host_req = '0; host_we = '0; host_be = '0; host_addr = '0; host_wdata = '0;
        dev_gnt = 0; dev_rvalid = 0; dev_err = 0; dev_rdata = '0;
        #1;
        chk("rst_busy", {63'd0, busy_a}, 64'd0);
        chk("rst_dev_req", {63'd0, dreq_a}, 64'd0);
        chk("rst_gnt_rvalid", {58'd0, gnt_a, rvalid_a}, 64'd0);
        chk("rst_timeout", {63'd0, tmo_a}, 64'd0);
        tick(); tick();
        rst = 1'b0;

        // Host 1 read, device grants in the second REQ cycle.
        host_req = 3'b010; host_addr[63:32] = 32'h100;
        settle(); chk("t1_idle_busy", {63'd0, busy_a}, 64'd0);
        tick(); settle();
        chk("t1_dev_req", {63'd0, dreq_a}, 64'd1);
        chk("t1_dev_addr", {32'd0, daddr_a}, 64'h100);
        chk("t1_dev_we", {63'd0, dwe_a}, 64'd0);
        chk("t1_no_gnt", {61'd0, gnt_a}, 64'd0);
        tick(); dev_gnt = 1; settle();
        chk("t1_gnt", {61'd0, gnt_a}, 64'b010);
        tick(); host_req = '0; dev_gnt = 0; dev_rvalid = 1; dev_rdata = 32'hDEADBEEF;
        settle();
        chk("t1_dev_req_drop", {63'd0, dreq_a}, 64'd0);
        chk("t1_rvalid", {61'd0, rvalid_a}, 64'b010);
        chk("t1_rdata", {32'd0, rdata_a}, 64'hDEADBEEF);
        chk("t1_err", {63'd0, err_a}, 64'd0);
        tick(); dev_rvalid = 0; settle();
        chk("t1_back_idle", {63'd0, busy_a}, 64'd0);
        chk("t1_rdata_zero", {32'd0, rdata_a}, 64'd0);

        // Host 2 write with partial byte enables.
        host_req = 3'b100; host_we = 3'b100; host_be[11:8] = 4'b0011;
        host_addr[95:64] = 32'h20; host_wdata[95:64] = 32'h1234;
        tick(); dev_gnt = 1; settle();
        chk("t3_dev_req", {63'd0, dreq_a}, 64'd1);
        chk("t3_dev_we", {63'd0, dwe_a}, 64'd1);
        chk("t3_dev_be", {60'd0, dbe_a}, 64'b0011);
        chk("t3_dev_addr", {32'd0, daddr_a}, 64'h20);
        chk("t3_dev_wdata", {32'd0, dwdata_a}, 64'h1234);
        chk("t3_gnt", {61'd0, gnt_a}, 64'b100);
        tick(); host_req = '0; host_we = '0; dev_gnt = 0; dev_rvalid = 1; dev_rdata = 32'hA5;
        settle();
        chk("t3_rvalid", {61'd0, rvalid_a}, 64'b100);
        tick(); dev_rvalid = 0;

        // Host 0 read, device reports an error.
        host_req = 3'b001;
        tick(); dev_gnt = 1; settle();
        chk("t5_gnt", {61'd0, gnt_a}, 64'b001);
        tick(); host_req = '0; dev_gnt = 0; dev_rvalid = 1; dev_err = 1; dev_rdata = 32'h55;
        settle();
        chk("t5_rvalid", {61'd0, rvalid_a}, 64'b001);
        chk("t5_err", {63'd0, err_a}, 64'd1);
        tick(); dev_rvalid = 0; dev_err = 0;

        // Host 1 read, device never answers.
        host_req = 3'b010;
        tick(); dev_gnt = 1; settle();
        tick(); host_req = '0; dev_gnt = 0; dev_rdata = 32'hFFFFFFFF;
        quiet = 1'b1;
        for (int i = 0; i < 16; i++) begin
            settle();
            if (rvalid_a !== 3'b000 || tmo_a !== 1'b0 || busy_a !== 1'b1) quiet = 1'b0;
            tick();
        end
        chk("t4_quiet_16_cycles", {63'd0, quiet}, 64'd1);
        settle();
        chk("t4_to_rvalid", {61'd0, rvalid_a}, 64'b010);
        chk("t4_to_err", {63'd0, err_a}, 64'd1);
        chk("t4_to_rdata", {32'd0, rdata_a}, 64'd0);
        tick(); settle();
        chk("t4_timeout_sticky", {63'd0, tmo_a}, 64'd1);
        chk("t4_idle", {63'd0, busy_a}, 64'd0);
        dev_rvalid = 1; settle();
        chk("t4_late_rvalid_dropped", {61'd0, rvalid_a}, 64'd0);
        chk("t4_late_rdata_zero", {32'd0, rdata_a}, 64'd0);
        tick(); dev_rvalid = 0;

        // Reset in the middle of a response, then all hosts compete.
        host_req = 3'b001;
        tick(); dev_gnt = 1;
        tick(); host_req = '0; dev_gnt = 0; settle();
        chk("t6_in_resp", {63'd0, busy_a}, 64'd1);
        host_req = 3'b111; dev_gnt = 1; dev_rvalid = 1; rst = 1'b1;
        #1;
        chk("t6_rst_busy", {63'd0, busy_a}, 64'd0);
        chk("t6_rst_dev_req", {63'd0, dreq_a}, 64'd0);
        chk("t6_rst_gnt_rvalid", {58'd0, gnt_a, rvalid_a}, 64'd0);
        chk("t6_rst_timeout", {63'd0, tmo_a}, 64'd0);
        tick(); tick();
        rst = 1'b0; settle();
        chk("t6_idle_gnt", {61'd0, gnt_a}, 64'd0);
        tick();

        // Back-to-back: a grant every other cycle.
        for (int k = 0; k < 12; k++) begin
            settle();
            exp_a = (k % 2 == 0) ? (3'b001 << ((k / 2) % 3)) : 3'b000;
            chk($sformatf("t2_rr_gnt_%0d", k), {61'd0, gnt_a}, {61'd0, exp_a});
            chk($sformatf("t2_fp_gnt_%0d", k), {61'd0, gnt_b},
                (k % 2 == 0) ? 64'b001 : 64'd0);
            tick();
        end
        host_req = '0; dev_gnt = 0; dev_rvalid = 0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
